// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - shared types and constants for the serial pattern detector
package seq_detector_pkg;

  // Detector states: no pattern, filling history, comparing, absorbing lockout
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  localparam int              HIT_W   = 8;
  localparam logic [HIT_W-1:0] HIT_MAX = 8'd255;

  // Saturating increment for the match counter
  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (v == HIT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_detector_shreg.sv
// rtl/seq_detector_shreg.sv - history shift register with valid-gated shift and clear
module seq_detector_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             d,
  output logic [WIDTH-2:0] q
);

  // New bit zero-extended so the shift works down to a single-bit history
  logic [WIDTH-2:0] d_ext;

  // Place the incoming bit in the lsb position
  always_comb begin
    d_ext    = '0;
    d_ext[0] = d;
  end

  // Clear has priority over shift; newest bit enters at the lsb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= (q << 1) | d_ext;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - Mealy serial pattern detector; optional lockout via SEQ_DETECTOR_LOCK_EN
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic [WIDTH-1:0] pat,
  input  logic             pat_load,
  input  logic             overlap,
  input  logic             clr,
  output logic             z,
  output logic [HIT_W-1:0] hit_cnt,
  output logic             locked
);

  localparam int               FW         = $clog2(WIDTH);
  localparam logic [FW-1:0]    FILL_TOP   = FW'(WIDTH - 1);
  localparam logic [HIT_W-1:0] MAX_HITS_V = HIT_W'(MAX_HITS);

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [FW-1:0]    fill;
  logic [WIDTH-2:0] hist;

  logic             clr_eff;
  logic             match;
  logic             lock_hit;
  logic             hist_clr;
  logic             hist_shift;

`ifdef SEQ_DETECTOR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
  assign locked = (state == ST_LOCK);
`else
  localparam bit LOCK_EN = 1'b0;
  assign locked = 1'b0;
`endif

  // clr only restarts a detector that already holds a pattern
  assign clr_eff  = clr && (state != ST_IDLE);

  // A load or clear cycle never reports a match; the bit on x is dropped
  assign match    = x_valid && (state == ST_RUN) && !pat_load && !clr
                    && ({hist, x} == pat_q);
  assign z        = match && !rst;

  // The match that brings the counter to MAX_HITS is the last one reported
  assign lock_hit = LOCK_EN && match && (hit_cnt != HIT_MAX)
                    && (sat_inc(hit_cnt) == MAX_HITS_V);

  assign hist_clr   = pat_load || clr_eff || (match && !overlap);
  assign hist_shift = x_valid && !pat_load && !clr_eff &&
                      ((state == ST_FILL) || ((state == ST_RUN) && (!match || overlap)));

  seq_detector_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .clr   (hist_clr),
    .shift (hist_shift),
    .d     (x),
    .q     (hist)
  );

  // State, pattern, fill count and match counter; load beats clear beats data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pat_q   <= '0;
      fill    <= '0;
      hit_cnt <= '0;
    end else if (pat_load) begin
      pat_q   <= pat;
      fill    <= '0;
      hit_cnt <= '0;
      state   <= ST_FILL;
    end else if (clr_eff) begin
      fill    <= '0;
      hit_cnt <= '0;
      state   <= ST_FILL;
    end else if (x_valid) begin
      case (state)
        ST_FILL: begin
          fill <= fill + FW'(1);
          if (fill == FILL_TOP - FW'(1)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (match) begin
            hit_cnt <= sat_inc(hit_cnt);
            if (lock_hit) begin
              state <= ST_LOCK;
            end else if (!overlap) begin
              fill  <= '0;
              state <= ST_FILL;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector against a queue-based reference model
module tb_seq_detector;

  localparam int W  = 4;
  localparam int MH = 2;
`ifdef SEQ_DETECTOR_LOCK_EN
  localparam bit LK_EN = 1'b1;
`else
  localparam bit LK_EN = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         x_valid  = 1'b0;
  logic         x        = 1'b0;
  logic [W-1:0] pat      = '0;
  logic         pat_load = 1'b0;
  logic         overlap  = 1'b0;
  logic         clr      = 1'b0;
  logic         z;
  logic [7:0]   hit_cnt;
  logic         locked;

  seq_detector #(
    .WIDTH    (W),
    .MAX_HITS (MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x        (x),
    .pat      (pat),
    .pat_load (pat_load),
    .overlap  (overlap),
    .clr      (clr),
    .z        (z),
    .hit_cnt  (hit_cnt),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit z;
    int hit;
    bit lk;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  bit   m_loaded = 1'b0;
  bit   m_locked = 1'b0;
  int   m_pat    = 0;
  int   m_hits   = 0;
  bit   m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic hist_push(input bit b);
    m_hist.push_back(b);
    if (m_hist.size() > W - 1) void'(m_hist.pop_front());
  endtask

  task automatic model(input bit r, input bit pl, input bit cl, input bit xv, input bit xb,
                       input bit ov, input logic [W-1:0] p, output exp_t e);
    int v;
    e.z   = 1'b0;
    e.cyc = 0;
    if (r) begin
      m_loaded = 1'b0;
      m_locked = 1'b0;
      m_pat    = 0;
      m_hits   = 0;
      m_hist.delete();
      e.hit    = 0;
      e.lk     = 1'b0;
      return;
    end
    e.hit = m_hits;
    e.lk  = m_locked;
    if (pl) begin
      m_pat    = int'(p);
      m_loaded = 1'b1;
      m_locked = 1'b0;
      m_hits   = 0;
      m_hist.delete();
    end else if (cl && m_loaded) begin
      m_locked = 1'b0;
      m_hits   = 0;
      m_hist.delete();
    end else if (m_loaded && !m_locked && xv) begin
      v = 0;
      foreach (m_hist[i]) v = (v << 1) | int'(m_hist[i]);
      v = (v << 1) | int'(xb);
      if (m_hist.size() == W - 1 && v == m_pat) begin
        e.z = 1'b1;
        if (m_hits < 255) begin
          m_hits++;
          if (LK_EN && m_hits == MH) m_locked = 1'b1;
        end
        if (ov) hist_push(xb);
        else    m_hist.delete();
      end else begin
        hist_push(xb);
      end
    end
  endtask

  task automatic step(input bit r, input bit pl, input bit cl, input bit xv, input bit xb,
                      input bit ov, input logic [W-1:0] p);
    exp_t e;
    @(posedge clk);
    #2;
    rst      = r;
    pat_load = pl;
    clr      = cl;
    x_valid  = xv;
    x        = xb;
    overlap  = ov;
    pat      = p;
    cyc++;
    model(r, pl, cl, xv, xb, ov, p, e);
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input bit ov, input int gap);
    logic [15:0] bv;
    bv = bits;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, bv[i], ov, '0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), ov, '0);
    end
  endtask

  task automatic load(input logic [W-1:0] p);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, p);
  endtask

  // Monitor: compare every presented output against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("z", {31'b0, z}, {31'b0, mon_e.z}, mon_e.cyc);
        check("hit_cnt", {24'b0, hit_cnt}, mon_e.hit, mon_e.cyc);
        check("locked", {31'b0, locked}, {31'b0, mon_e.lk}, mon_e.cyc);
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0);

    load(4'b1011); feed(16'b1011011, 7, 1'b1, 0);
    load(4'b1011); feed(16'b1011011, 7, 1'b0, 0);
    load(4'b1011); feed(16'b1011, 4, 1'b1, 2);

    load(4'b1011); feed(16'b101, 3, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    feed(16'b1011, 4, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0);

    load(4'b1011); feed(16'b101110111011, 12, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0);
    feed(16'b10111011, 8, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
    feed(16'b0110110, 7, 1'b1, 0);

    load(4'b0000);
    for (int i = 0; i < 270; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 200) == 0, ($urandom % 100) < 3, ($urandom % 100) < 2,
           ($urandom % 100) < 75, 1'($urandom), 1'($urandom), W'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0, cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
